// File: rtl/sw_pattern_gen_if.sv
// sw_pattern_gen_if
// Groups the run-control, stimulus and result signals of the switch
// pattern generator. The clock and reset stay outside the interface.
//
//   start   : run request, sampled on the rising clock edge
//   abort   : terminates a run in progress
//   led_in  : LED code returned by the switch-driven FSM under test
//   sw      : registered switch code driven to the FSM under test
//   busy    : high while a sequence is being driven
//   done    : one-cycle pulse at normal run completion
//   pass    : last completed run had zero mismatches
//   err_cnt : mismatch count of the current or last run (saturating)
//
// master : the requester / FSM under test side
// slave  : the pattern generator
interface sw_pattern_gen_if;
    logic       start;
    logic       abort;
    logic [2:0] led_in;
    logic [2:0] sw;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;

    modport master (
        output start, abort, led_in,
        input  sw, busy, done, pass, err_cnt
    );

    modport slave (
        input  start, abort, led_in,
        output sw, busy, done, pass, err_cnt
    );
endinterface

// File: rtl/sw_pattern_gen.sv
// sw_pattern_gen
// Drives a fixed 8-step switch code sequence into a switch-driven FSM under
// test, holding each code for HOLD_CYCLES clocks. On the last cycle of each
// hold the returned LED code is compared with the code being driven, and
// mismatches are counted (saturating at 15). A completed run pulses done and
// loads pass; an abort during the run returns to idle without done.
//
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sw_pattern_gen_if.slave (start, abort, led_in in;
//           sw, busy, done, pass, err_cnt out)
//
// Parameter HOLD_CYCLES : cycles each code is held, legal range 1..255.
module sw_pattern_gen #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sw_pattern_gen_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] step;
    logic [7:0] hold_cnt;
    logic [2:0] sw_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_q;

    logic       mismatch;
    logic [3:0] err_next;

    // Fixed stimulus sequence; the expected LED code equals the driven code.
    function automatic logic [2:0] rom_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;
            3'd1:    code = 3'b010;
            3'd2:    code = 3'b100;
            3'd3:    code = 3'b111;
            3'd4:    code = 3'b100;
            3'd5:    code = 3'b000;
            3'd6:    code = 3'b010;
            default: code = 3'b100;
        endcase
        return code;
    endfunction

    // Error count as it would stand after a compare on this edge; used both
    // to update err_cnt and so that pass sees a mismatch found at step 7.
    always_comb begin
        mismatch = (bus.led_in != rom_code(step));
        err_next = err_q;
        if (mismatch && (err_q != 4'd15)) begin
            err_next = err_q + 4'd1;
        end
    end

    // Single FSM with all outputs registered. done defaults low so it can
    // only be high for the one cycle spent in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 3'd0;
            hold_cnt <= 8'd0;
            sw_q     <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over abort here; abort has no meaning in IDLE
                    if (bus.start) begin
                        state    <= DRIVE;
                        step     <= 3'd0;
                        hold_cnt <= 8'd0;
                        err_q    <= 4'd0;
                        pass_q   <= 1'b0;
                        sw_q     <= rom_code(3'd0);
                        busy_q   <= 1'b1;
                    end
                end
                DRIVE: begin
                    // abort also beats the step-7 compare on the same edge
                    if (bus.abort) begin
                        state    <= IDLE;
                        step     <= 3'd0;
                        hold_cnt <= 8'd0;
                        sw_q     <= 3'b000;
                        busy_q   <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= 8'd0;
                        err_q    <= err_next;
                        if (step == 3'd7) begin
                            state  <= DONE;
                            step   <= 3'd0;
                            sw_q   <= 3'b000;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_next == 4'd0);
                        end else begin
                            step <= step + 3'd1;
                            sw_q <= rom_code(step + 3'd1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    sw_q   <= 3'b000;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sw      = sw_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_sw_pattern_gen.sv
// tb_sw_pattern_gen
// Self-checking bench for sw_pattern_gen. Two instances share clk/rst_n:
// u4 with HOLD_CYCLES=4 and u1 with HOLD_CYCLES=1; sel chooses which one
// receives stimulus and is observed. For each run the expected per-cycle
// outputs are pushed into a scoreboard queue when the run is launched and
// popped and compared one entry per clock as the DUT produces them.
module tb_sw_pattern_gen;

    typedef struct {
        logic [2:0] sw;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       start_d;
    logic       abort_d;
    logic [2:0] led_d;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    logic [2:0] rom [0:7] = '{3'b001, 3'b010, 3'b100, 3'b111,
                              3'b100, 3'b000, 3'b010, 3'b100};

    sw_pattern_gen_if bus4 ();
    sw_pattern_gen_if bus1 ();

    assign bus4.start  = ~sel & start_d;
    assign bus4.abort  = ~sel & abort_d;
    assign bus4.led_in = led_d;
    assign bus1.start  = sel & start_d;
    assign bus1.abort  = sel & abort_d;
    assign bus1.led_in = led_d;

    logic [2:0] obs_sw;
    logic       obs_busy;
    logic       obs_done;
    logic       obs_pass;
    logic [3:0] obs_err;

    assign obs_sw   = sel ? bus1.sw      : bus4.sw;
    assign obs_busy = sel ? bus1.busy    : bus4.busy;
    assign obs_done = sel ? bus1.done    : bus4.done;
    assign obs_pass = sel ? bus1.pass    : bus4.pass;
    assign obs_err  = sel ? bus1.err_cnt : bus4.err_cnt;

    sw_pattern_gen #(.HOLD_CYCLES(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    sw_pattern_gen #(.HOLD_CYCLES(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LED code the FSM under test returns during run cycle c.
    // mode 0: echoes the driven code, mode 1: stuck at 000,
    // mode 2: echoes except 111 during step 7.
    function automatic logic [2:0] ledModel(input int mode, input int c, input int h);
        int step;
        if (c >= 8 * h) return 3'b000;
        step = c / h;
        case (mode)
            0:       return rom[step];
            1:       return 3'b000;
            default: return (step == 7) ? 3'b111 : rom[step];
        endcase
    endfunction

    task automatic checkIdle(input string tag, input logic exp_pass, input logic [3:0] exp_err);
        checkOutput({tag, "_sw"},   32'(obs_sw),   32'd0);
        checkOutput({tag, "_busy"}, 32'(obs_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(obs_done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(obs_pass), 32'(exp_pass));
        checkOutput({tag, "_err"},  32'(obs_err),  32'(exp_err));
    endtask

    // Launches one run. Cycle c is the cycle after the c-th edge counted
    // from the start-sampling edge (c=0). abort_cyc / restart_cyc raise
    // abort / start during that cycle; reset_cyc pulls rst_n low part way
    // through that cycle. Negative values disable the feature.
    task automatic applyStimulus(input int h_sel, input int mode, input int abort_cyc,
                                 input int restart_cyc, input int reset_cyc,
                                 input bit abort_with_start);
        int   h;
        int   n;
        int   err;
        int   step;
        bit   aborted;
        exp_t e;

        h       = (h_sel != 0) ? 1 : 4;
        sel     = (h_sel != 0);
        n       = (abort_cyc >= 0) ? abort_cyc + 5 :
                  (reset_cyc >= 0) ? reset_cyc + 1 : 8 * h + 3;
        err     = 0;
        aborted = 1'b0;
        sb.delete();

        for (int c = 0; c < n; c++) begin
            if (!aborted && c < 8 * h) begin
                step = c / h;
                e = '{rom[step], 1'b1, 1'b0, 1'b0, 4'(err)};
                if ((c % h == h - 1) && c != abort_cyc) begin
                    if (ledModel(mode, c, h) != rom[step] && err < 15) err++;
                end
                if (c == abort_cyc) aborted = 1'b1;
            end else if (aborted) begin
                e = '{3'b000, 1'b0, 1'b0, 1'b0, 4'(err)};
            end else if (c == 8 * h) begin
                e = '{3'b000, 1'b0, 1'b1, (err == 0), 4'(err)};
            end else begin
                e = '{3'b000, 1'b0, 1'b0, (err == 0), 4'(err)};
            end
            sb.push_back(e);
        end

        @(negedge clk);
        start_d = 1'b1;
        abort_d = abort_with_start;
        led_d   = 3'b000;

        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start_d = (c == restart_cyc);
            abort_d = (c == abort_cyc);
            led_d   = ledModel(mode, c, h);
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("run_sw",   32'(obs_sw),   32'(e.sw));
                checkOutput("run_busy", 32'(obs_busy), 32'(e.busy));
                checkOutput("run_done", 32'(obs_done), 32'(e.done));
                checkOutput("run_pass", 32'(obs_pass), 32'(e.pass));
                checkOutput("run_err",  32'(obs_err),  32'(e.err));
            end
        end
        start_d = 1'b0;
        abort_d = 1'b0;
        led_d   = 3'b000;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        if (reset_cyc >= 0) begin
            // Still well before the next clock edge: reset must act at once.
            #2;
            rst_n = 1'b0;
            #1;
            checkIdle("async_rst", 1'b0, 4'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                checkIdle("post_rst", 1'b0, 4'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        start_d = 1'b0;
        abort_d = 1'b0;
        led_d   = 3'b000;

        #3;
        checkIdle("in_reset", 1'b0, 4'd0);
        #9;
        rst_n = 1'b1;

        // No start after reset release: outputs stay idle.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkIdle("rst_idle", 1'b0, 4'd0);
        end

        $display("[TB] loopback run, HOLD_CYCLES=4");
        applyStimulus(0, 0, -1, -1, -1, 1'b0);
        $display("[TB] stuck-at-000 run, HOLD_CYCLES=4");
        applyStimulus(0, 1, -1, -1, -1, 1'b0);
        $display("[TB] abort in step 3, HOLD_CYCLES=4");
        applyStimulus(0, 0, 13, -1, -1, 1'b0);
        $display("[TB] abort on the step-7 compare edge, HOLD_CYCLES=4");
        applyStimulus(0, 0, 31, -1, -1, 1'b0);
        $display("[TB] restart in step 2 and reset in step 6, HOLD_CYCLES=4");
        applyStimulus(0, 1, -1, 9, 25, 1'b0);
        $display("[TB] step-7 mismatch, HOLD_CYCLES=1");
        applyStimulus(1, 2, -1, -1, -1, 1'b0);
        $display("[TB] start and abort together in IDLE, HOLD_CYCLES=1");
        applyStimulus(1, 0, -1, -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_pattern_gen.md
SW_PATTERN_GEN -- requirements
Module: sw_pattern_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of clock cycles each switch code is held; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops use the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a run request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port abort, input, 1, which terminates a run in progress.
REQ-006 The block SHALL have port led_in, input, 3, the LED code returned by the switch-driven FSM under test.
REQ-007 The block SHALL have port sw, output, 3, the registered switch code driven to the FSM under test.
REQ-008 The block SHALL have port busy, output, 1, which is high while a sequence is being driven.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at normal run completion.
REQ-010 The block SHALL have port pass, output, 1, which is high when the last completed run had zero mismatches.
REQ-011 The block SHALL have port err_cnt, output, 4, the mismatch count for the current or last run, saturating.

Function
REQ-012 The block SHALL hold a fixed 8-entry sequence ROM: step0..7 = 001, 010, 100, 111, 100, 000, 010, 100.
REQ-013 The block SHALL use expected led_in for step k equal to ROM[k].
REQ-014 The block SHALL implement a state machine with states IDLE, DRIVE and DONE.
REQ-015 IDLE SHALL drive sw=000 with busy=0; start=1 SHALL cause a transition to DRIVE, set step=0, set hold_cnt=0, clear err_cnt and clear pass.
REQ-016 DRIVE SHALL drive sw=ROM[step] with busy=1; the first sw=001 SHALL appear in the cycle after the start sample edge.
REQ-017 In DRIVE, hold_cnt SHALL increment each cycle; when hold_cnt==HOLD_CYCLES-1, led_in SHALL be compared with ROM[step] on that edge, hold_cnt SHALL clear, and step SHALL advance.
REQ-018 On a mismatch, err_cnt SHALL increment, saturating at 15; a match SHALL leave err_cnt unchanged.
REQ-019 After the compare at step 7, the FSM SHALL move to DONE; DRIVE SHALL therefore last exactly 8*HOLD_CYCLES cycles.
REQ-020 DONE SHALL last exactly one cycle, with done=1, busy=0 and sw=000; pass SHALL be loaded as (err_cnt==0), including any step-7 mismatch; the next state SHALL be IDLE.
REQ-021 start SHALL be ignored while in DRIVE or DONE.
REQ-022 abort=1 in DRIVE SHALL force IDLE on the next edge with sw=000; done SHALL NOT pulse, pass SHALL stay 0, and err_cnt SHALL be retained; abort in IDLE or DONE SHALL have no effect.
REQ-023 If start and abort are both high in IDLE, start SHALL win and the run SHALL begin.
REQ-024 If abort is high on the same edge as the step-7 compare, abort SHALL win: the state goes to IDLE and done does not pulse.
REQ-025 When HOLD_CYCLES=1, each code SHALL be held one cycle and compared every cycle.
REQ-026 pass and err_cnt SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force the state to IDLE, sw=000, busy=0, done=0, pass=0, err_cnt=0, step=0 and hold_cnt=0, regardless of the clock.
REQ-028 Reset asserted mid-run SHALL abandon the run immediately; after release, the block SHALL wait in IDLE for start.

Verification
REQ-029 The bench SHALL pulse rst_n low, then release it, with no start -> sw=000, busy=0, done=0, pass=0, err_cnt=0, held indefinitely.
REQ-030 The bench SHALL run HOLD_CYCLES=4 with led_in looped back from sw and start pulsed for one cycle -> sw steps 001,010,100,111,100,000,010,100, 4 cycles each, busy high 32 cycles, done for 1 cycle, pass=1, err_cnt=0.
REQ-031 The bench SHALL run HOLD_CYCLES=4 with led_in stuck at 000 -> 7 mismatches (step 5 matches), err_cnt=7, pass=0, done pulses once.
REQ-032 The bench SHALL run HOLD_CYCLES=4 with abort during step 3, hold_cnt=1 -> next cycle sw=000 and busy=0, no done pulse, pass=0, err_cnt=0 held.
REQ-033 The bench SHALL pulse start again during step 2 and assert rst_n=0 during step 6 -> the second start has no effect, and the reset immediately sets sw=000, busy=0 and err_cnt=0 without waiting for a clock edge.
REQ-034 The bench SHALL run HOLD_CYCLES=1 with led_in=sw except step 7 forced to 111 -> busy high 8 cycles, err_cnt=1, pass=0, done pulses once.
